// File: rtl/edge_writer.sv
// Edge-map writer: queues per-pixel results in a small FIFO and streams them to
// an output memory as {addr, data} writes, tracking frame state and edge count.
module edge_writer #(
  parameter int IMG_W  = 8,
  parameter int DEPTH  = 4,
  parameter bit BINARY = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        In_Valid,
  input  logic        In_End,
  input  logic [7:0]  In_Row,
  input  logic [7:0]  In_Column,
  input  logic [7:0]  In_Gradient,
  input  logic        In_Dop,
  input  logic        Mem_Ready,
  output logic        Mem_We,
  output logic [15:0] Mem_Addr,
  output logic [7:0]  Mem_Data,
  output logic [15:0] Edge_Count,
  output logic        Busy,
  output logic        Done,
  output logic        Overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  state_t        state;
  wr_entry_t     fifo_mem [DEPTH];
  wr_entry_t     push_ent, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   occ;
  logic          frame_start, push_req, pop, full, accept, drop;

  always_comb begin
    push_req    = In_Valid && (state != S_DRAIN);
    frame_start = In_Valid && ((state == S_IDLE) || (state == S_DONE));
    full        = (occ == (PW+1)'(DEPTH));
    pop         = Mem_We && Mem_Ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    accept      = push_req && (!full || pop);
    drop        = push_req && full && !pop;
    push_ent.addr = {8'd0, In_Row} * 16'(IMG_W) + {8'd0, In_Column};
    push_ent.data = BINARY ? (In_Dop ? 8'hFF : 8'h00) : In_Gradient;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      Edge_Count <= '0;
      Overflow   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (In_Valid) state <= In_End ? S_DRAIN : S_RUN;
        S_RUN:          if (In_End) state <= S_DRAIN;
        S_DRAIN:        if (occ == '0) state <= S_DONE;
        default:        state <= S_IDLE;
      endcase

      if (accept) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop)    rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (accept && !pop)      occ <= occ + 1'b1;
      else if (!accept && pop) occ <= occ - 1'b1;

      // The FIFO is always empty at frame start, so the first sample is never dropped.
      if (frame_start) begin
        Overflow   <= 1'b0;
        Edge_Count <= {15'd0, In_Dop};
      end else begin
        if (drop) Overflow <= 1'b1;
        if (accept && In_Dop && (Edge_Count != 16'hFFFF)) Edge_Count <= Edge_Count + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset && accept) fifo_mem[wr_ptr] <= push_ent;
  end

  assign head     = fifo_mem[rd_ptr];
  assign Mem_We   = (occ != '0);
  assign Mem_Addr = Mem_We ? head.addr : 16'd0;
  assign Mem_Data = Mem_We ? head.data : 8'd0;
  assign Busy     = (state == S_RUN) || (state == S_DRAIN);
  assign Done     = (state == S_DONE);

endmodule

// File: tb/tb_edge_writer.sv
// Bench for edge_writer: binary and raw-gradient instances share stimulus and are
// checked every cycle against a queue-based frame model plus directed literals.
module tb_edge_writer;
  localparam int IMG_W = 8;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, v, e, dop, rdy;
  logic [7:0]  row, col, grad;
  logic        we_b, we_r, busy_b, busy_r, done_b, done_r, ovf_b, ovf_r;
  logic [15:0] addr_b, addr_r, ecnt_b, ecnt_r;
  logic [7:0]  data_b, data_r;

  edge_writer #(.IMG_W(IMG_W), .DEPTH(DEPTH), .BINARY(1'b1)) dut_b (
    .Clk(clk), .Reset(rst_n), .In_Valid(v), .In_End(e), .In_Row(row), .In_Column(col),
    .In_Gradient(grad), .In_Dop(dop), .Mem_Ready(rdy), .Mem_We(we_b), .Mem_Addr(addr_b),
    .Mem_Data(data_b), .Edge_Count(ecnt_b), .Busy(busy_b), .Done(done_b), .Overflow(ovf_b));

  edge_writer #(.IMG_W(IMG_W), .DEPTH(DEPTH), .BINARY(1'b0)) dut_r (
    .Clk(clk), .Reset(rst_n), .In_Valid(v), .In_End(e), .In_Row(row), .In_Column(col),
    .In_Gradient(grad), .In_Dop(dop), .Mem_Ready(rdy), .Mem_We(we_r), .Mem_Addr(addr_r),
    .Mem_Data(data_r), .Edge_Count(ecnt_r), .Busy(busy_r), .Done(done_r), .Overflow(ovf_r));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: frame phase, a queue of pending writes, sticky flag, counter.
  typedef struct {int addr; int db; int dr;} ent_t;
  ent_t mq[$];
  int   m_ph = P_IDLE, m_ovf = 0, m_ecnt = 0;
  bit   m_ok = 1'b0;

  always @(posedge clk) begin : mdl
    int   sz;
    bit   popd, req, start;
    ent_t ent;
    if (!rst_n) begin
      mq.delete();
      m_ph = P_IDLE; m_ovf = 0; m_ecnt = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      sz    = mq.size();
      popd  = (sz > 0) && rdy;
      req   = v && (m_ph != P_DRAIN);
      start = v && ((m_ph == P_IDLE) || (m_ph == P_DONE));
      if (popd) void'(mq.pop_front());
      if (start) begin m_ovf = 0; m_ecnt = 0; end
      if (req) begin
        if (mq.size() < DEPTH) begin
          ent.addr = (int'(row) * IMG_W + int'(col)) % 65536;
          ent.db   = dop ? 255 : 0;
          ent.dr   = int'(grad);
          mq.push_back(ent);
          if (dop && m_ecnt < 65535) m_ecnt++;
        end else m_ovf = 1;
      end
      case (m_ph)
        P_IDLE, P_DONE: if (v) m_ph = e ? P_DRAIN : P_RUN;
        P_RUN:          if (e) m_ph = P_DRAIN;
        P_DRAIN:        if (sz == 0) m_ph = P_DONE;
        default:        m_ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin : cmp
    int exp_we;
    if (m_ok) begin
      exp_we = (mq.size() > 0) ? 1 : 0;
      chk("we_b", we_b, exp_we);
      chk("we_r", we_r, exp_we);
      if (exp_we != 0) begin
        chk("addr_b", addr_b, mq[0].addr);
        chk("data_b", data_b, mq[0].db);
        chk("addr_r", addr_r, mq[0].addr);
        chk("data_r", data_r, mq[0].dr);
      end
      chk("busy_b", busy_b, (m_ph == P_RUN || m_ph == P_DRAIN) ? 1 : 0);
      chk("done_b", done_b, (m_ph == P_DONE) ? 1 : 0);
      chk("ovf_b", ovf_b, m_ovf);
      chk("ecnt_b", ecnt_b, m_ecnt);
      chk("busy_r", busy_r, (m_ph == P_RUN || m_ph == P_DRAIN) ? 1 : 0);
      chk("ovf_r", ovf_r, m_ovf);
      chk("ecnt_r", ecnt_r, m_ecnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit vv, input bit ee, input int r, input int c, input bit d, input int g);
    v = vv; e = ee; row = 8'(r); col = 8'(c); dop = d; grad = 8'(g);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, we_b, 0);
    chk({tag, "_addr"}, addr_b, 0);
    chk({tag, "_data"}, data_b, 0);
    chk({tag, "_data_r"}, data_r, 0);
    chk({tag, "_ecnt"}, ecnt_b, 0);
    chk({tag, "_busy"}, busy_b, 0);
    chk({tag, "_done"}, done_b, 0);
    chk({tag, "_ovf"}, ovf_b, 0);
  endtask

  initial begin
    int rdy_pct;
    rst_n = 1'b0; rdy = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Three samples straight through with the memory always ready
    drive(1, 0, 0, 0, 1, 8'h11); tick();
    chk("d1_we", we_b, 1); chk("d1_addr", addr_b, 0); chk("d1_data", data_b, 8'hFF);
    chk("d1_raw", data_r, 8'h11);
    drive(1, 0, 0, 1, 0, 8'h22); tick();
    chk("d2_addr", addr_b, 1); chk("d2_data", data_b, 8'h00);
    drive(1, 1, 1, 2, 1, 8'h33); tick();
    chk("d3_addr", addr_b, 10); chk("d3_data", data_b, 8'hFF); chk("d3_ecnt", ecnt_b, 2);
    chk("d3_busy", busy_b, 1);
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("drain_we", we_b, 0); chk("drain_busy", busy_b, 1); chk("drain_done", done_b, 0);
    tick();
    chk("done_done", done_b, 1); chk("done_busy", busy_b, 0);

    // Stalled memory: five samples into a four-entry FIFO
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 3, i, (i != 2), i); tick();
      chk("stall_we", we_b, 1); chk("stall_addr", addr_b, 24);
    end
    chk("stall_ovf", ovf_b, 1); chk("stall_ecnt", ecnt_b, 3);
    drive(0, 0, 0, 0, 0, 0); rdy = 1'b1;
    chk("rel_addr0", addr_b, 24);
    for (int i = 1; i < 4; i++) begin
      tick(); chk("rel_addr", addr_b, 24 + i); chk("rel_we", we_b, 1);
    end
    tick(); chk("rel_empty", we_b, 0);
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    chk("rel_done", done_b, 1);

    // Full FIFO with simultaneous push and pop
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(1, 0, 4, i, 1, 0); tick(); end
    chk("full_ovf0", ovf_b, 0); chk("full_addr", addr_b, 32);
    drive(1, 0, 4, 4, 1, 0); rdy = 1'b1; tick();
    chk("pp_ovf", ovf_b, 0); chk("pp_addr", addr_b, 33); chk("pp_ecnt", ecnt_b, 5);
    drive(0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && !done_b; k++) tick();
    chk("pp_done", done_b, 1);

    // Reset with three entries pending, a valid sample held during reset
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1, 0, 5, i, 1, 0); tick(); end
    chk("pend_we", we_b, 1);
    drive(1, 0, 6, 6, 1, 0); rst_n = 1'b0; tick();
    chk_reset_vals("mid_rst");
    rst_n = 1'b1; drive(0, 0, 0, 0, 0, 0); rdy = 1'b1;
    tick(); tick();
    chk("post_rst_we", we_b, 0); chk("post_rst_busy", busy_b, 0);

    // Raw gradient at (2,3), single-sample frame
    drive(1, 1, 2, 3, 0, 8'h5A); tick();
    chk("raw_addr", addr_r, 19); chk("raw_data", data_r, 8'h5A); chk("raw_bin", data_b, 0);
    drive(0, 0, 0, 0, 0, 0); tick(); tick();
    chk("raw_done", done_r, 1);

    // Randomized traffic with varying memory back-pressure
    rdy_pct = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) rdy_pct = (n % 300 == 0) ? 20 : ((n % 300 == 100) ? 60 : 95);
      rst_n = ($urandom_range(0, 249) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 255));
      rdy = ($urandom_range(0, 99) < rdy_pct);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/edge_writer.md
EDGE_WRITER -- requirements
Module: edge_writer

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels; used for address generation.
REQ-002 Parameter DEPTH, default 4: FIFO entries, power of two.
REQ-003 Parameter BINARY, default 1: 1 = write edge map (FF/00); 0 = write raw gradient.
REQ-004 Clk  in  1: single clock; all state changes on the rising edge.
REQ-005 Reset  in  1: synchronous, active-low reset.
REQ-006 In_Valid  in  1: gradient sample valid this cycle (driven by the datapath isReady).
REQ-007 In_End  in  1: last sample of the frame (driven by the datapath isEnd).
REQ-008 In_Row, In_Column  in  8 each: pixel coordinates of the sample.
REQ-009 In_Gradient  in  8: gradient magnitude.
REQ-010 In_Dop  in  1: edge decision, gradient above threshold.
REQ-011 Mem_Ready  in  1: output memory accepts a write this cycle.
REQ-012 Mem_We  out  1: write request.
REQ-013 Mem_Addr  out  16: write address.
REQ-014 Mem_Data  out  8: write data.
REQ-015 Edge_Count  out  16: edge pixels in the current frame.
REQ-016 Busy  out  1: FSM is in RUN or DRAIN.
REQ-017 Done  out  1: frame complete.
REQ-018 Overflow  out  1: sticky flag; a sample was dropped.

Function
REQ-019 FSM has four states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE or DONE with In_Valid=1 -> RUN; that sample is pushed; Edge_Count restarts from this sample; Overflow clears; Done falls.
REQ-021 RUN with In_End=1 (In_Valid may be high in the same cycle; that sample is pushed) -> DRAIN.
REQ-022 DRAIN -> DONE in the cycle after the FIFO becomes empty; In_Valid is ignored in DRAIN.
REQ-023 A sample arriving with In_Valid=1 and In_End=1 in IDLE or DONE is pushed and the FSM goes directly to DRAIN.
REQ-024 Each FIFO entry holds {addr, data}.
REQ-025 addr = In_Row*IMG_W + In_Column, computed as a 16-bit unsigned value, truncated modulo 2^16.
REQ-026 data = In_Dop ? 8'hFF : 8'h00 when BINARY=1; data = In_Gradient when BINARY=0.
REQ-027 Mem_We = FIFO not empty; Mem_Addr and Mem_Data = FIFO head.
REQ-028 A transfer occurs when Mem_We=1 and Mem_Ready=1; the head is popped in that same cycle.
REQ-029 Mem_Addr and Mem_Data hold stable while Mem_We=1 and Mem_Ready=0.
REQ-030 Latency: a sample pushed at edge n appears on Mem_We/Mem_Addr/Mem_Data after edge n (one cycle) if the FIFO was empty.
REQ-031 Push and pop in the same cycle are both performed; when the FIFO is full, the pop frees the slot and the push is accepted.
REQ-032 A push while full with no pop drops the sample and sets Overflow; Overflow stays set until the next frame start or reset.
REQ-033 Edge_Count increments on each accepted push with In_Dop=1 and saturates at 16'hFFFF.
REQ-034 Dropped samples are not counted.
REQ-035 Busy=1 in RUN and DRAIN only.
REQ-036 Done=1 in DONE only; Done holds until the next frame starts.
REQ-037 FIFO pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit or an occupancy counter.

Reset
REQ-038 Reset=0 at a clock edge gives: state IDLE; FIFO empty; Mem_We=0; Mem_Addr=0; Mem_Data=0; Edge_Count=0; Busy=0; Done=0; Overflow=0.
REQ-039 Reset mid-frame discards all FIFO contents; no further writes occur until a new In_Valid arrives.
REQ-040 Reset takes priority over every other input in the same cycle.

Verification
REQ-041 Bench covers: Mem_Ready=1, IMG_W=8, samples (0,0,D=1), (0,1,D=0), (1,2,D=1) -> writes addr 0/FF, 1/00, 10/FF, each one cycle after its input; Edge_Count=2.
REQ-042 Bench covers: In_End with the last sample -> DRAIN, then DONE after the FIFO empties; Done=1, Busy=0.
REQ-043 Bench covers: Mem_Ready=0, 5 consecutive samples with DEPTH=4 -> 4 stored, Overflow=1, Mem_Addr held stable; then Mem_Ready=1 -> exactly 4 writes in order.
REQ-044 Bench covers: FIFO full, In_Valid=1 and Mem_Ready=1 in the same cycle -> no drop, Overflow stays 0.
REQ-045 Bench covers: Reset=0 while 3 entries are pending -> Mem_We=0 on the next cycle, all outputs at reset values.
REQ-046 Bench covers: BINARY=0, In_Gradient=8'h5A at (2,3) -> Mem_Addr=19, Mem_Data=8'h5A.
